// File: rtl/idp_muldiv.sv
// idp_muldiv: register file, scratch registers, ALU with flags, HI/LO, Y mux and an
// iterative multiply/divide unit. Define IDP_MD_SIGNED_EN to enable signed md_op[1].
module idp_muldiv #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int RA_IDX = NREG - 1,
  parameter int SP_IDX = NREG - 3,
  localparam int AW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_en,
  input  logic [1:0]    da_sel,
  input  logic          t_sel,
  input  logic [2:0]    y_sel,
  input  logic [3:0]    fs,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] t_addr,
  input  logic [DW-1:0] dt,
  input  logic [DW-1:0] dy,
  input  logic [DW-1:0] pc_in,
  input  logic          md_start,
  input  logic [1:0]    md_op,
  output logic          md_busy,
  output logic          md_done,
  output logic          div_by_zero,
  output logic          c,
  output logic          v,
  output logic          n,
  output logic          z,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] d_out
);
  localparam int SHW = $clog2(DW);
  localparam int CW  = $clog2(DW);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rs_q, rt_q, alu_r_q, din_q, hi_q, lo_q;
  logic [DW-1:0] s_rd, t_rd, alu_res;
  logic [AW-1:0] wa;
  logic          alu_c, alu_v;

  // ---------------- register file ----------------
  assign s_rd = (s_addr == '0) ? '0 : rf_q[s_addr];
  assign t_rd = (t_addr == '0) ? '0 : rf_q[t_addr];

  always_comb begin
    wa = d_addr;
    case (da_sel)
      2'd0:    wa = d_addr;
      2'd1:    wa = t_addr;
      2'd2:    wa = AW'(RA_IDX);
      default: wa = AW'(SP_IDX);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (d_en && (wa != '0)) begin
      rf_q[wa] <= alu_out;
    end
  end

  // ---------------- scratch registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q    <= '0;
      rt_q    <= '0;
      alu_r_q <= '0;
      din_q   <= '0;
    end else begin
      rs_q    <= s_rd;
      rt_q    <= t_sel ? dt : t_rd;
      alu_r_q <= alu_res;
      din_q   <= dy;
    end
  end

  // ---------------- ALU ----------------
  logic [DW:0]     add_x, sub_x;
  logic [SHW-1:0]  shamt;
  assign add_x = {1'b0, rs_q} + {1'b0, rt_q};
  assign sub_x = {1'b0, rs_q} - {1'b0, rt_q};
  assign shamt = rt_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fs)
      4'd0:  alu_res = rs_q;
      4'd1:  alu_res = rt_q;
      4'd2: begin
        alu_res = add_x[DW-1:0];
        alu_c   = add_x[DW];
        alu_v   = (rs_q[DW-1] == rt_q[DW-1]) && (add_x[DW-1] != rs_q[DW-1]);
      end
      4'd3: begin
        // carry on subtract is the inverted borrow
        alu_res = sub_x[DW-1:0];
        alu_c   = ~sub_x[DW];
        alu_v   = (rs_q[DW-1] != rt_q[DW-1]) && (sub_x[DW-1] != rs_q[DW-1]);
      end
      4'd4:  alu_res = rs_q & rt_q;
      4'd5:  alu_res = rs_q | rt_q;
      4'd6:  alu_res = rs_q ^ rt_q;
      4'd7:  alu_res = ~(rs_q | rt_q);
      4'd8:  alu_res = {{(DW-1){1'b0}}, ($signed(rs_q) < $signed(rt_q))};
      4'd9:  alu_res = {{(DW-1){1'b0}}, (rs_q < rt_q)};
      4'd10: alu_res = rs_q << shamt;
      4'd11: alu_res = rs_q >> shamt;
      4'd12: alu_res = $signed(rs_q) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  assign c = alu_c;
  assign v = alu_v;
  assign n = alu_res[DW-1];
  assign z = (alu_res == '0);

  // ---------------- multiply / divide ----------------
  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*DW-1:0] acc_q, acc_nx;
  logic [DW-1:0]   opb_q;
  logic            div_q, neg_q, rneg_q, busy_q, done_q, dbz_q;
  logic [DW:0]     mul_sum, div_trial;
  logic            sgn, a_neg, b_neg, dbz_now;
  logic [DW-1:0]   a_mag, b_mag;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quo_fix, rem_fix;

`ifdef IDP_MD_SIGNED_EN
  assign sgn = md_op[1];
`else
  // md_op[1] has no effect in an unsigned-only build
  assign sgn = md_op[1] & 1'b0;
`endif

  assign a_neg = sgn & rs_q[DW-1];
  assign b_neg = sgn & rt_q[DW-1];
  assign a_mag = a_neg ? -rs_q : rs_q;
  assign b_mag = b_neg ? -rt_q : rt_q;

  // acc holds {HI-side, LO-side}: multiplier/product for mul, remainder/quotient for div
  assign mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_trial = {acc_q[2*DW-1:DW], acc_q[DW-1]} - {1'b0, opb_q};

  always_comb begin
    acc_nx = {mul_sum, acc_q[DW-1:1]};
    if (div_q) begin
      if (!div_trial[DW]) acc_nx = {div_trial[DW-1:0], acc_q[DW-2:0], 1'b1};
      else                acc_nx = {acc_q[2*DW-2:0], 1'b0};
    end
  end

  // zero divisor already yields all-ones quotient and dividend remainder; keep LO unsigned
  assign dbz_now  = div_q && (opb_q == '0);
  assign prod_fix = neg_q ? -acc_nx : acc_nx;
  assign quo_fix  = (neg_q && !dbz_now) ? -acc_nx[DW-1:0] : acc_nx[DW-1:0];
  assign rem_fix  = rneg_q ? -acc_nx[2*DW-1:DW] : acc_nx[2*DW-1:DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          done_q <= 1'b0;
          if (md_start) begin
            acc_q   <= {{DW{1'b0}}, a_mag};
            opb_q   <= b_mag;
            div_q   <= md_op[0];
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            dbz_q   <= 1'b0;
            cnt_q   <= CW'(DW - 1);
            busy_q  <= 1'b1;
            state_q <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc_q <= acc_nx;
          if (cnt_q == '0) begin
            if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*DW-1:DW];
              lo_q <= prod_fix[DW-1:0];
            end
            dbz_q   <= dbz_now;
            done_q  <= 1'b1;
            state_q <= MD_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MD_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign md_busy     = busy_q;
  assign md_done     = done_q;
  assign div_by_zero = dbz_q;

  // ---------------- Y mux ----------------
  always_comb begin
    alu_out = alu_r_q;
    case (y_sel)
      3'd1:    alu_out = hi_q;
      3'd2:    alu_out = lo_q;
      3'd3:    alu_out = din_q;
      3'd4:    alu_out = pc_in;
      3'd5:    alu_out = {{(DW-2){1'b0}}, dbz_q, busy_q};
      default: alu_out = alu_r_q;
    endcase
  end

  assign d_out = rt_q;

endmodule
